// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the serial-in / parallel-out deserializer:
//   state_t    - framing state (IDLE: no bits held, SHIFT: partial word held)
//   cnt_width  - width of the bit counter for a given data width
// -----------------------------------------------------------------------------
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must reach WIDTH (the parity bit position) with headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// -----------------------------------------------------------------------------
// sipo_shift_core
// Shift register plus bit counter. Collects N serial bits (MSB first) per word
// and raises word_done combinationally during the cycle whose rising edge
// samples the Nth bit, so the consumer can capture word_data on that same edge.
//
// Parameters:
//   WIDTH  data bits per word (2..32)
//   N      bits per frame: WIDTH, or WIDTH+1 when a parity bit trails the data
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   shift_en    sample serial_in on this edge
//   serial_in   serial data, MSB first
//   frame_sync  restart word alignment
//   word_done   high when this edge completes a frame
//   word_data   data bits of the completing frame (bit WIDTH-1 = first bit)
// -----------------------------------------------------------------------------
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic             frame_sync,
  output logic             word_done,
  output logic [WIDTH-1:0] word_data
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_t          state, state_next;
  logic [CW-1:0]   bit_cnt, bit_cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;

  // Without parity the final data bit is the one being sampled right now;
  // with parity the register already holds all data bits and serial_in is
  // the parity bit.
  assign word_data = (N == WIDTH) ? {shift_reg[WIDTH-2:0], serial_in} : shift_reg;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    word_done    = 1'b0;
    if (shift_en) begin
      shift_next = {shift_reg[WIDTH-2:0], serial_in};
      if (frame_sync) begin
        // Partial word dropped; this sample is bit 1 of the new word.
        bit_cnt_next = CW'(1);
        state_next   = SHIFT;
      end else if (bit_cnt == LAST_IDX) begin
        // Nth bit: complete and rearm on the same edge, no dead cycle.
        word_done    = 1'b1;
        bit_cnt_next = '0;
        state_next   = IDLE;
      end else begin
        bit_cnt_next = bit_cnt + CW'(1);
        state_next   = SHIFT;
      end
    end else if (frame_sync) begin
      bit_cnt_next = '0;
      state_next   = IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
// Serial-in / parallel-out deserializer with a one-word output holding
// register, valid/ready handshake and a sticky overrun flag.
//
// Build option: define SIPO_PARITY_EN to append an even-parity bit to every
// frame (N = WIDTH+1); parity_err reports the check for the held word.
// Without it frames are WIDTH bits and parity_err is tied to 0.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   shift_en      sample serial_in on this edge
//   serial_in     serial data, MSB first
//   frame_sync    restart word alignment
//   out_ready     consumer accepts the held word (with out_valid)
//   overrun_clr   clears the sticky overrun flag
//   parallel_out  last accepted word, bit WIDTH-1 = first received bit
//   out_valid     parallel_out holds an unconsumed word
//   overrun       sticky: a completed word was dropped
//   parity_err    parity result for the held word
// -----------------------------------------------------------------------------
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic             frame_sync,
  input  logic             out_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif

  logic             word_done;
  logic [WIDTH-1:0] word_data;
  logic             word_perr;
  logic             can_load;
  logic             drop;

  sipo_shift_core #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (shift_en),
    .serial_in  (serial_in),
    .frame_sync (frame_sync),
    .word_done  (word_done),
    .word_data  (word_data)
  );

`ifdef SIPO_PARITY_EN
  // Even parity: data plus parity bit must XOR to 0.
  assign word_perr = ^{word_data, serial_in};
`else
  assign word_perr = 1'b0;
`endif

  // A completed word may enter the holding register if it is empty or is
  // being consumed on this very edge; otherwise it is lost.
  assign can_load = !out_valid || out_ready;
  assign drop     = word_done && !can_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
      parity_err   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (word_done && can_load) begin
        parallel_out <= word_data;
        parity_err   <= word_perr;
        out_valid    <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid    <= 1'b0;
      end
      // A fresh drop wins over a simultaneous clear.
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_sipo_deser
// Self-checking bench for sipo_deser (WIDTH=4). A frame-level reference model
// (queue of received bits, word formed when the queue holds N bits) predicts
// all outputs after every clock edge.
// -----------------------------------------------------------------------------
module tb_sipo_deser;

  localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
  localparam int N   = WIDTH + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int N   = WIDTH;
  localparam bit PAR = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             shift_en;
  logic             serial_in;
  logic             frame_sync;
  logic             out_ready;
  logic             overrun_clr;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             overrun;
  logic             parity_err;

  int total;
  int bad;

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .shift_en     (shift_en),
    .serial_in    (serial_in),
    .frame_sync   (frame_sync),
    .out_ready    (out_ready),
    .overrun_clr  (overrun_clr),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .overrun      (overrun),
    .parity_err   (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic             frame_q[$];
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ovr;
  logic             m_perr;

  task automatic model_reset();
    frame_q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endtask

  // Applies the inputs present at a rising edge.
  task automatic model_edge();
    bit               done;
    int               acc;
    logic             p;
    logic             dropped;
    done = 1'b0;
    acc  = 0;
    p    = 1'b0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (frame_sync) frame_q.delete();
    if (shift_en) begin
      frame_q.push_back(serial_in);
      if (frame_q.size() == N) begin
        done = 1'b1;
        for (int i = 0; i < WIDTH; i++) acc = acc * 2 + int'(frame_q[i]);
        if (PAR) for (int i = 0; i < N; i++) p = p ^ frame_q[i];
        frame_q.delete();
      end
    end
    dropped = done && m_valid && !out_ready;
    if (done && (!m_valid || out_ready)) begin
      m_data  = WIDTH'(acc);
      m_perr  = p;
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (dropped) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
  endtask

  function automatic logic [WIDTH+2:0] exp_pack();
    return {m_valid, m_data, m_ovr, m_perr};
  endfunction

  function automatic logic [WIDTH+2:0] obs();
    return {out_valid, parallel_out, overrun, parity_err};
  endfunction

  task automatic drive(input logic se, input logic si, input logic fs,
                       input logic rdy, input logic oclr);
    shift_en    = se;
    serial_in   = si;
    frame_sync  = fs;
    out_ready   = rdy;
    overrun_clr = oclr;
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
    #2;
    total++;
    if (obs() !== '0) begin
      bad++;
      $display("FAIL reset_initial: got %b want %b", obs(), {(WIDTH+3){1'b0}});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs() !== '0) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: got %b want all zero", i, obs());
      end
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_single_word();
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pat[3-i], 1'b0, 1'b1, 1'b0);
      tick();
      total++;
      if (obs() !== exp_pack()) begin
        bad++;
        $display("FAIL single_word bit%0d: got %b want %b", i, obs(), exp_pack());
      end
    end
    total++;
    if (parallel_out !== 4'b1001 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_word_done: got data=%b valid=%b want data=1001 valid=1",
               parallel_out, out_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_word_consumed: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    pat = 8'b1100_0110;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, pat[7-i], 1'b0, 1'b1, 1'b0);
      tick();
      total++;
      if (obs() !== exp_pack()) begin
        bad++;
        $display("FAIL back_to_back bit%0d: got %b want %b", i, obs(), exp_pack());
      end
      if (i == 3) begin
        total++;
        if (parallel_out !== 4'b1100 || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL back_to_back_w1: got data=%b valid=%b want 1100/1",
                   parallel_out, out_valid);
        end
      end
    end
    total++;
    if (parallel_out !== 4'b0110 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back_w2: got data=%b valid=%b ovr=%b want 0110/1/0",
               parallel_out, out_valid, overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_overrun();
    logic [7:0] pat;
    logic [3:0] pat2;
    pat  = 8'b1001_1100;
    pat2 = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, pat[7-i], 1'b0, 1'b0, 1'b0);
      tick();
      total++;
      if (obs() !== exp_pack()) begin
        bad++;
        $display("FAIL overrun bit%0d: got %b want %b", i, obs(), exp_pack());
      end
    end
    total++;
    if (parallel_out !== 4'b1001 || out_valid !== 1'b1 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_held: got data=%b valid=%b ovr=%b want 1001/1/1",
               parallel_out, out_valid, overrun);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    total++;
    if (overrun !== 1'b0 || parallel_out !== 4'b1001) begin
      bad++;
      $display("FAIL overrun_clr: got ovr=%b data=%b want 0/1001", overrun, parallel_out);
    end
    // Clear coinciding with a fresh drop: the drop wins.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pat2[3-i], 1'b0, 1'b0, 1'b1);
      tick();
    end
    total++;
    if (overrun !== 1'b1 || parallel_out !== 4'b1001) begin
      bad++;
      $display("FAIL overrun_clr_vs_set: got ovr=%b data=%b want 1/1001",
               overrun, parallel_out);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    total++;
    if (obs() !== exp_pack() || out_valid !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_drain: got %b want %b", obs(), exp_pack());
    end
  endtask

  task automatic test_frame_sync();
    // Columns: step 0 first (MSB). Partial 11 then resync into 0110.
    logic [5:0] se_a, si_a, fs_a;
    logic [6:0] se_b, si_b, fs_b;
    se_a = 6'b111111; si_a = 6'b110110; fs_a = 6'b001000;
    for (int i = 0; i < 6; i++) begin
      drive(se_a[5-i], si_a[5-i], fs_a[5-i], 1'b1, 1'b0);
      tick();
      total++;
      if (obs() !== exp_pack()) begin
        bad++;
        $display("FAIL frame_sync_a step%0d: got %b want %b", i, obs(), exp_pack());
      end
    end
    total++;
    if (parallel_out !== 4'b0110 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL frame_sync_word: got data=%b valid=%b want 0110/1",
               parallel_out, out_valid);
    end
    // Resync without a sample: partial 10 dropped, next word is 1010.
    se_b = 7'b1101111; si_b = 7'b1001010; fs_b = 7'b0010000;
    for (int i = 0; i < 7; i++) begin
      drive(se_b[6-i], si_b[6-i], fs_b[6-i], 1'b1, 1'b0);
      tick();
      total++;
      if (obs() !== exp_pack()) begin
        bad++;
        $display("FAIL frame_sync_b step%0d: got %b want %b", i, obs(), exp_pack());
      end
    end
    total++;
    if (parallel_out !== 4'b1010 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL frame_sync_idle: got data=%b valid=%b want 1010/1",
               parallel_out, out_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] pat;
    pat = 4'b1001;
    // Park a word in the holder, then start another frame.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b0;
    #2;
    model_reset();
    total++;
    if (obs() !== '0) begin
      bad++;
      $display("FAIL reset_async: got %b want all zero", obs());
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pat[3-i], 1'b0, 1'b1, 1'b0);
      tick();
      total++;
      if (obs() !== exp_pack()) begin
        bad++;
        $display("FAIL reset_mid_word bit%0d: got %b want %b", i, obs(), exp_pack());
      end
    end
    total++;
    if (parallel_out !== 4'b1001 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_word_done: got data=%b valid=%b want 1001/1",
               parallel_out, out_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    logic [9:0] pat;
    pat = 10'b10010_10011;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, pat[9-i], 1'b0, 1'b1, 1'b0);
      tick();
      if (i == 4) begin
        total++;
        if (parallel_out !== 4'b1001 || parity_err !== 1'b0 || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL parity_good: got data=%b perr=%b want 1001/0",
                   parallel_out, parity_err);
        end
      end
    end
    total++;
    if (parallel_out !== 4'b1001 || parity_err !== 1'b1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL parity_bad: got data=%b perr=%b want 1001/1",
               parallel_out, parity_err);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask
`endif

  task automatic test_random();
    int errs_here;
    errs_here = 0;
    for (int c = 0; c < 600; c++) begin
      drive(($urandom % 4) != 0, 1'($urandom), ($urandom % 16) == 0,
            1'($urandom), ($urandom % 8) == 0);
      tick();
      total++;
      if (obs() !== exp_pack()) begin
        bad++;
        errs_here++;
        if (errs_here <= 10)
          $display("FAIL random cyc%0d: got %b want %b", c, obs(), exp_pack());
      end
      if (!PAR) begin
        total++;
        if (parity_err !== 1'b0) begin
          bad++;
          $display("FAIL parity_off cyc%0d: got perr=%b want 0", c, parity_err);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #3;
    test_reset();
`ifdef SIPO_PARITY_EN
    test_parity();
`else
    test_single_word();
    test_back_to_back();
    test_overrun();
    test_frame_sync();
    test_reset_mid_word();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
